// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq
//  Description : Program-counter sequencer. Supports increment, absolute jump,
//                PC-relative branch, and call/return through a circular
//                return-address stack.
//                Define PC_SEQ_RAS_EN to build the return-address stack. When
//                it is undefined, CALL acts as JMP, RET acts as INC, and the
//                stack status and fault outputs are tied off.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_seq #(
    parameter int                     ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                     RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic                  fault_clr,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  fault
);

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_JMP    = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_WIDTH'(1);

`ifdef PC_SEQ_RAS_EN
    localparam int                PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);

    // The top pointer indexes the most recent entry. When the stack is full,
    // the slot after the top holds the oldest entry, so a push there
    // overwrites the oldest entry without any additional bookkeeping.
    logic [ADDR_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]      top_q;
    logic [PTR_W-1:0]      top_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  fault_q;
    logic                  fault_d;
    logic                  fault_set;
    logic                  push_en;
    logic [PTR_W-1:0]      push_idx;
    logic                  cnt_zero;
    logic                  cnt_full;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_full = (cnt_q == FULL_CNT);
    assign push_idx = top_q + PTR_W'(1);
`endif

    // Next-PC and stack-pointer selection for the sampled operation.
    always_comb begin
        pc_d      = pc_q;
`ifdef PC_SEQ_RAS_EN
        top_d     = top_q;
        cnt_d     = cnt_q;
        push_en   = 1'b0;
        fault_set = 1'b0;
`endif
        if (en) begin
            case (op)
                OP_INC:    pc_d = pc_inc;
                OP_JMP:    pc_d = addr_in;
                OP_BRANCH: pc_d = pc_q + offset;
                OP_CALL: begin
                    pc_d = addr_in;
`ifdef PC_SEQ_RAS_EN
                    push_en = 1'b1;
                    top_d   = push_idx;
                    if (cnt_full) begin
                        fault_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
                OP_RET: begin
`ifdef PC_SEQ_RAS_EN
                    if (cnt_zero) begin
                        pc_d      = pc_inc;
                        fault_set = 1'b1;
                    end else begin
                        pc_d  = ras_mem_q[top_q];
                        top_d = top_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`else
                    pc_d = pc_inc;
`endif
                end
                default:   pc_d = pc_inc;
            endcase
        end
    end

`ifdef PC_SEQ_RAS_EN
    // Sticky fault: a new overflow or underflow takes priority over a clear.
    always_comb begin
        fault_d = fault_set | (fault_q & ~fault_clr);
    end

    // PC, stack pointer, count and fault registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Stack storage. Its contents are not reset because a zero count makes
    // stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem_q[push_idx] <= pc_inc;
        end
    end

    assign ras_empty = cnt_zero;
    assign ras_full  = cnt_full;
    assign fault     = fault_q;
`else
    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Without a stack, the clear input and the depth parameter have no effect.
    logic unused_cfg;
    assign unused_cfg = &{1'b0, fault_clr, (RAS_DEPTH > 0)};

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign fault     = 1'b0;
`endif

    assign addr_out = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_seq
//  Description : Self-checking bench for pc_seq. It applies fixed vectors,
//                hand sequences for the stack corner cases, and random
//                stimulus compared against a queue-based reference model.
//                Expectations follow PC_SEQ_RAS_EN in the same way as the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

    localparam logic [15:0] RV = 16'h0100;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  op;
    logic [15:0] addr_in;
    logic [15:0] offset;
    logic        fault_clr;
    logic [15:0] addr_out;
    logic        ras_empty;
    logic        ras_full;
    logic        fault;

    int checks = 0;
    int errors = 0;

    pc_seq #(
        .ADDR_WIDTH   (16),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .op        (op),
        .addr_in   (addr_in),
        .offset    (offset),
        .fault_clr (fault_clr),
        .addr_out  (addr_out),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_fault;

    task automatic m_reset();
        m_pc    = RV;
        m_stk   = {};
        m_fault = 1'b0;
    endtask

    task automatic m_step(input logic e, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] f, input logic c);
        logic set;
        set = 1'b0;
        if (e) begin
            if (o == 3'd1) m_pc = a;
            else if (o == 3'd2) m_pc = 16'(m_pc + f);
            else if (o == 3'd3) begin
                if (RAS) begin
                    if (m_stk.size() == 4) begin
                        void'(m_stk.pop_front());
                        set = 1'b1;
                    end
                    m_stk.push_back(16'(m_pc + 16'd1));
                end
                m_pc = a;
            end else if (o == 3'd4 && RAS) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc = 16'(m_pc + 16'd1);
                    set  = 1'b1;
                end
            end else m_pc = 16'(m_pc + 16'd1);
        end
        if (set) m_fault = 1'b1;
        else if (c) m_fault = 1'b0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic e, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] f, input logic c);
        en = e; op = o; addr_in = a; offset = f; fault_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [15:0] pc, input logic emp,
                             input logic full, input logic flt);
        check({name, " pc"},    32'(addr_out),  32'(pc));
        check({name, " empty"}, 32'(ras_empty), 32'(emp));
        check({name, " full"},  32'(ras_full),  32'(full));
        check({name, " fault"}, 32'(fault),     32'(flt));
    endtask

    // Asserts reset between edges, checks the asynchronous effect, holds it
    // across one edge, then releases it away from the edge.
    task automatic do_reset();
        reset = 1'b0;
        #3;
        expect_st("async reset", RV, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_st("reset held", RV, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] off;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0101};
        vecs[1]  = '{1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0102};
        vecs[2]  = '{1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0103};
        vecs[3]  = '{1'b1, 3'd1, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[4]  = '{1'b1, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 3'd1, 16'h0010, 16'h0000, 16'h0010};
        vecs[6]  = '{1'b1, 3'd2, 16'h0000, 16'hFFF0, 16'h0000};
        vecs[7]  = '{1'b1, 3'd2, 16'h0000, 16'h0005, 16'h0005};
        vecs[8]  = '{1'b0, 3'd1, 16'h1234, 16'h0000, 16'h0005};
        vecs[9]  = '{1'b0, 3'd1, 16'h1234, 16'h0000, 16'h0005};
        vecs[10] = '{1'b1, 3'd5, 16'h1234, 16'h0000, 16'h0006};
        vecs[11] = '{1'b1, 3'd7, 16'h1234, 16'h0000, 16'h0007};
        vecs[12] = '{1'b1, 3'd2, 16'h0000, 16'h0000, 16'h0007};
        vecs[13] = '{1'b1, 3'd2, 16'h0000, 16'hFFFF, 16'h0006};

        reset = 1'b0; en = 1'b0; op = 3'd0; addr_in = '0; offset = '0; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_st("power-on reset", RV, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;

        // Fixed vectors from reset release.
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].off, 1'b0);
            check($sformatf("vec%0d pc", i), 32'(addr_out), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d empty", i), 32'(ras_empty), 32'd1);
        end

        // A single call followed by a return.
        do_reset();
        apply(1'b1, 3'd1, 16'h0020, 16'h0, 1'b0);
        expect_st("jmp 0020", 16'h0020, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 3'd3, 16'h0400, 16'h0, 1'b0);
        expect_st("call 0400", 16'h0400, !RAS, 1'b0, 1'b0);
        apply(1'b1, 3'd4, 16'h0000, 16'h0, 1'b0);
        expect_st("ret", RAS ? 16'h0021 : 16'h0401, 1'b1, 1'b0, 1'b0);

        // Overflow on the fifth call, then unwind and underflow.
        do_reset();
        apply(1'b1, 3'd1, 16'h0000, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 3'd3, 16'((i + 1) * 16), 16'h0, 1'b0);
            expect_st($sformatf("call%0d", i), 16'((i + 1) * 16), !RAS,
                      RAS && (i >= 3), RAS && (i == 4));
        end
        for (int j = 0; j < 4; j++) begin
            apply(1'b1, 3'd4, 16'h0, 16'h0, 1'b0);
            expect_st($sformatf("ret%0d", j),
                      RAS ? 16'(16'h41 - 16 * j) : 16'(16'h51 + j),
                      !RAS || (j == 3), 1'b0, RAS);
        end
        apply(1'b1, 3'd4, 16'h0, 16'h0, 1'b0);
        expect_st("ret underflow", RAS ? 16'h0012 : 16'h0055, 1'b1, 1'b0, RAS);
        apply(1'b1, 3'd4, 16'h0, 16'h0, 1'b1);
        expect_st("underflow beats clear", RAS ? 16'h0013 : 16'h0056, 1'b1, 1'b0, RAS);
        apply(1'b0, 3'd1, 16'h1234, 16'h0, 1'b1);
        expect_st("clear while stalled", RAS ? 16'h0013 : 16'h0056, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 3'd1, 16'h1234, 16'h0, 1'b0);
        expect_st("stall holds", RAS ? 16'h0013 : 16'h0056, 1'b1, 1'b0, 1'b0);

        // A reset that lands on an in-flight jump discards the jump.
        en = 1'b1; op = 3'd1; addr_in = 16'h1234;
        do_reset();

        // Random stimulus against the model.
        m_reset();
        for (int n = 0; n < 600; n++) begin
            logic        e;
            logic [2:0]  o;
            logic [15:0] a;
            logic [15:0] f;
            logic        c;
            e = ($urandom_range(0, 7) != 0);
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) o = 3'd3;
            else if ($urandom_range(0, 2) == 0) o = 3'd4;
            a = 16'($urandom);
            f = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7) - 4);
            c = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 79) == 0) begin
                en = e; op = o; addr_in = a; offset = f; fault_clr = c;
                do_reset();
                m_reset();
            end else begin
                apply(e, o, a, f, c);
                m_step(e, o, a, f, c);
                expect_st($sformatf("rand%0d", n), m_pc, (m_stk.size() == 0),
                          (m_stk.size() == 4), m_fault);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of program counter, offset and all address ports.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: address loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2..16.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  advance enable; 0 = stall.
REQ-007 SHALL have port op  input  3  operation: 000 INC, 001 JMP, 010 BRANCH, 011 CALL, 100 RET, 101..111 reserved.
REQ-008 SHALL have port addr_in  input  ADDR_WIDTH  absolute target for JMP/CALL.
REQ-009 SHALL have port offset  input  ADDR_WIDTH  two's-complement displacement for BRANCH.
REQ-010 SHALL have port fault_clr  input  1  clears fault.
REQ-011 SHALL have port addr_out  output  ADDR_WIDTH  current PC, driven directly from register.
REQ-012 SHALL have port ras_empty  output  1  stack holds zero entries.
REQ-013 SHALL have port ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-014 SHALL have port fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-015 en=0 SHALL hold PC, stack contents, stack count and fault, regardless of op; fault_clr is still honoured.
REQ-016 INC SHALL load PC+1, modulo 2^ADDR_WIDTH; all-ones wraps to 0.
REQ-017 JMP SHALL load addr_in.
REQ-018 BRANCH SHALL load PC+offset, modulo 2^ADDR_WIDTH; offset is sign-interpreted, and the target is relative to the current PC, not PC+1.
REQ-019 CALL SHALL push PC+1 (wrapped) and load addr_in in the same cycle.
REQ-020 CALL with ras_full=1 SHALL overwrite the oldest entry, keep count at RAS_DEPTH, load addr_in and set fault.
REQ-021 RET with ras_empty=0 SHALL load the top entry and decrement count.
REQ-022 RET with ras_empty=1 SHALL load PC+1 and set fault.
REQ-023 Reserved op codes SHALL behave as INC.
REQ-024 Stack SHALL be LIFO. The stack is implemented as a circular buffer with a top pointer and a count; pointers wrap modulo RAS_DEPTH.
REQ-025 Every operation SHALL take effect in one cycle: addr_out shows the new PC on the edge after the operation is sampled.
REQ-026 ras_empty and ras_full SHALL reflect the registered count with no combinational path from inputs.
REQ-027 fault_clr=1 SHALL clear fault on the next edge; if a new fault event occurs in the same cycle, set wins.

Reset
REQ-028 reset=0 SHALL, asynchronously: set addr_out=RESET_VECTOR, count=0, top pointer=0, fault=0, ras_empty=1, ras_full=0.
REQ-029 Stack entry contents SHALL NOT require reset.
REQ-030 reset asserted mid-operation SHALL discard the in-flight operation.
REQ-031 The first operation after deassertion SHALL be the one sampled on the first rising edge with reset=1.

Configuration
REQ-032 Macro PC_SEQ_RAS_EN defined SHALL compile in the stack and behaviour REQ-019..REQ-022.
REQ-033 Macro PC_SEQ_RAS_EN undefined SHALL remove the stack storage. In that build:
- CALL behaves as JMP.
- RET behaves as INC.
- ras_empty is tied to 1, ras_full to 0, fault to 0.
- RAS_DEPTH is ignored.

Verification
REQ-034 Reset release with RESET_VECTOR=16'h0100, then en=1, op=INC for 3 cycles -> addr_out 0100, 0101, 0102, 0103.
REQ-035 PC=16'hFFFF, op=INC -> 0000. PC=16'h0010, op=BRANCH, offset=16'hFFF0 -> 0000.
REQ-036 PC=0x0020, CALL addr_in=0x0400 -> PC=0x0400, ras_empty=0. Next cycle RET -> PC=0x0021, ras_empty=1, fault=0.
REQ-037 RAS_DEPTH=4: 5 CALLs from PCs 0,0x10,0x20,0x30,0x40 -> ras_full=1, fault=1. Then 4 RETs -> PCs 0x41,0x31,0x21,0x11, then ras_empty=1. A 5th RET -> PC+1 with fault still 1.
REQ-038 en=0 with op=JMP, addr_in=0x1234 for 2 cycles -> PC unchanged. fault=1 with fault_clr=1 -> fault=0 next edge. reset pulsed low mid-cycle -> addr_out=RESET_VECTOR immediately, without waiting for an edge.
REQ-039 Build without PC_SEQ_RAS_EN: CALL addr_in=0x0400 -> PC=0x0400 and ras_empty=1. RET -> PC=0x0401 with fault=0.
